// File: rtl/irrigation_zone_controller.sv
// -----------------------------------------------------------------------------
// irrigation_zone_controller
//
// Tank and irrigation valve controller. Drives one tank fill valve and ZONES
// zone valves. Zones that request water get time-sliced round-robin slots of
// WATER_CYCLES clocks. Filling depends on the tank level thresholds and on the
// fertiliser/cleaning interlocks. A zone that selects both dripper and
// sprinkler mode forces the FAULT state, which closes every valve.
//
// Ports:
//   clock       in   system clock, rising edge
//   reset       in   asynchronous, active-low reset
//   level       in   [LEVEL_W-1:0] unsigned tank level
//   dripper     in   [ZONES-1:0] per-zone dripper mode select
//   sprinkler   in   [ZONES-1:0] per-zone sprinkler mode select
//   fertilised  in   fertiliser dosed; filling inhibited
//   cleaning    in   tank cleaning in progress; filling inhibited
//   filling     out  fill valve open
//   watering    out  any zone valve open
//   zone_valve  out  [ZONES-1:0] one-hot open zone valve; zero when not watering
//   active_zone out  [$clog2(ZONES)-1:0] granted zone; holds the last grant
//   error       out  high while in FAULT
//
// Every output is a register, so a valve change appears one cycle after the
// input that causes it is sampled.
// -----------------------------------------------------------------------------
module irrigation_zone_controller #(
    parameter int ZONES          = 4,
    parameter int LEVEL_W        = 8,
    parameter int FULL_LEVEL     = 200,
    parameter int CRITICAL_LEVEL = 20,
    parameter int WATER_CYCLES   = 16,
    parameter int TIMER_W        = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [LEVEL_W-1:0]         level,
    input  logic [ZONES-1:0]           dripper,
    input  logic [ZONES-1:0]           sprinkler,
    input  logic                       fertilised,
    input  logic                       cleaning,
    output logic                       filling,
    output logic                       watering,
    output logic [ZONES-1:0]           zone_valve,
    output logic [$clog2(ZONES)-1:0]   active_zone,
    output logic                       error
);

    localparam int ZW = $clog2(ZONES);

    localparam logic [LEVEL_W-1:0] FULL_L     = LEVEL_W'(FULL_LEVEL);
    localparam logic [LEVEL_W-1:0] CRITICAL_L = LEVEL_W'(CRITICAL_LEVEL);
    localparam logic [TIMER_W-1:0] SLOT_LOAD  = TIMER_W'(WATER_CYCLES - 1);
    localparam logic [ZONES-1:0]   ONE_HOT0   = ZONES'(1);
    localparam logic [ZW-1:0]      LAST_ZONE  = ZW'(ZONES - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WATERING = 2'd1,
        FILLING  = 2'd2,
        FAULT    = 2'd3
    } state_t;

    state_t               state_reg;
    logic [ZW-1:0]        ptr_reg;
    logic [TIMER_W-1:0]   timer_reg;

    // ---------------------------------------------------------------------
    // Input decode
    // ---------------------------------------------------------------------
    logic [ZONES-1:0] req;
    logic             conflict;
    logic             fill_ok;
    logic             full;
    logic             critical;

    genvar gi;
    generate
        for (gi = 0; gi < ZONES; gi++) begin : g_req
            // A zone requests water when exactly one mode is selected.
            assign req[gi] = dripper[gi] ^ sprinkler[gi];
        end
    endgenerate

    assign conflict = |(dripper & sprinkler);
    assign fill_ok  = !fertilised && !cleaning;
    assign full     = (level >= FULL_L);
    assign critical = (level <= CRITICAL_L);

    // ---------------------------------------------------------------------
    // Circular first-set search: returns {found, index} of the first set
    // request at or after start, wrapping from ZONES-1 back to 0.
    // ---------------------------------------------------------------------
    function automatic logic [ZW:0] pick(input logic [ZONES-1:0] r,
                                         input logic [ZW-1:0]    start);
        logic          found;
        logic [ZW-1:0] idx;
        logic [ZW:0]   c;
        found = 1'b0;
        idx   = start;
        for (int k = 0; k < ZONES; k++) begin
            c = {1'b0, start} + (ZW+1)'(k);
            if (c >= (ZW+1)'(ZONES)) begin
                c = c - (ZW+1)'(ZONES);
            end
            if (!found && r[c[ZW-1:0]]) begin
                found = 1'b1;
                idx   = c[ZW-1:0];
            end
        end
        return {found, idx};
    endfunction

    logic [ZW-1:0] ptr_next;      // pointer after the current slot
    logic [ZW:0]   idle_pick;     // grant search from the stored pointer
    logic [ZW:0]   slot_pick;     // grant search at a slot boundary
    logic          slot_end;

    always_comb begin
        ptr_next  = (active_zone == LAST_ZONE) ? '0 : active_zone + ZW'(1);
        idle_pick = pick(req, ptr_reg);
        slot_pick = pick(req, ptr_next);
        // The slot also ends early when the granted zone drops its request.
        slot_end  = (timer_reg == '0) || !req[active_zone];
    end

    // ---------------------------------------------------------------------
    // FSM with registered outputs
    // ---------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            ptr_reg     <= '0;
            timer_reg   <= '0;
            active_zone <= '0;
            filling     <= 1'b0;
            watering    <= 1'b0;
            zone_valve  <= '0;
            error       <= 1'b0;
        end else if (conflict) begin
            state_reg  <= FAULT;
            filling    <= 1'b0;
            watering   <= 1'b0;
            zone_valve <= '0;
            error      <= 1'b1;
        end else begin
            case (state_reg)
                FAULT: begin
                    state_reg <= IDLE;
                    error     <= 1'b0;
                end

                IDLE: begin
                    if (critical && fill_ok) begin
                        state_reg <= FILLING;
                        filling   <= 1'b1;
                    end else if (full && idle_pick[ZW]) begin
                        state_reg   <= WATERING;
                        active_zone <= idle_pick[ZW-1:0];
                        timer_reg   <= SLOT_LOAD;
                        watering    <= 1'b1;
                        zone_valve  <= ONE_HOT0 << idle_pick[ZW-1:0];
                    end
                end

                WATERING: begin
                    if (critical) begin
                        watering   <= 1'b0;
                        zone_valve <= '0;
                        if (fill_ok) begin
                            state_reg <= FILLING;
                            filling   <= 1'b1;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end else if (slot_end) begin
                        ptr_reg <= ptr_next;
                        if (slot_pick[ZW]) begin
                            // Next zone takes over on the same edge: no gap.
                            active_zone <= slot_pick[ZW-1:0];
                            timer_reg   <= SLOT_LOAD;
                            zone_valve  <= ONE_HOT0 << slot_pick[ZW-1:0];
                        end else begin
                            state_reg  <= IDLE;
                            watering   <= 1'b0;
                            zone_valve <= '0;
                        end
                    end else begin
                        timer_reg <= timer_reg - TIMER_W'(1);
                    end
                end

                FILLING: begin
                    if (!fill_ok || full) begin
                        state_reg <= IDLE;
                        filling   <= 1'b0;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule
